// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 bicolour frame store feeding the LED row scanner.
// Define FB_COPY_ON_SWAP_EN to reload the back bank from the new front bank at each swap.
module led_frame_buffer #(
    parameter logic [1:0] CLR_COLOR = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_x,
    input  logic [2:0]  wr_y,
    input  logic [1:0]  wr_color,
    input  logic        clr_req,
    output logic        clr_busy,
    input  logic        swap_req,
    input  logic        frame_start,
    output logic        swap_pend,
    output logic        swap_done,
    output logic [63:0] matrix_r,
    output logic [63:0] matrix_g
);

    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  row_q;
    logic        front_sel;
    logic        swap_fire, swap_fire_q;
    logic        wr_fire;
    logic [5:0]  wr_idx;
    logic [63:0] r_a, g_a, r_b, g_b;
    logic [63:0] back_r, back_g, front_r, front_g;
    logic [63:0] back_r_nx, back_g_nx, front_r_nx, front_g_nx;

    always_comb begin
        state_d   = state_q;
        wr_ready  = 1'b0;
        clr_busy  = 1'b0;
        swap_pend = 1'b0;
        swap_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_ready = !clr_req && !swap_req;
                if (clr_req)
                    state_d = CLEAR;
                else if (swap_req)
                    state_d = SWAP_WAIT;
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (row_q == 3'd7)
                    state_d = IDLE;
            end
            SWAP_WAIT: begin
                swap_pend = 1'b1;
                if (frame_start) begin
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_fire = wr_valid && wr_ready;
    assign wr_idx  = {wr_y, wr_x};

    assign front_r = front_sel ? r_b : r_a;
    assign front_g = front_sel ? g_b : g_a;
    assign back_r  = front_sel ? r_a : r_b;
    assign back_g  = front_sel ? g_a : g_b;

    always_comb begin
        back_r_nx  = back_r;
        back_g_nx  = back_g;
        front_r_nx = front_r;
        front_g_nx = front_g;
        if (wr_fire) begin
            back_r_nx[wr_idx] = wr_color[0];
            back_g_nx[wr_idx] = wr_color[1];
        end
        if (clr_busy) begin
            back_r_nx[{row_q, 3'b000} +: 8] = {8{CLR_COLOR[0]}};
            back_g_nx[{row_q, 3'b000} +: 8] = {8{CLR_COLOR[1]}};
        end
`ifdef FB_COPY_ON_SWAP_EN
        // Outgoing front bank becomes the new back bank, seeded with the new image.
        if (swap_fire) begin
            front_r_nx = back_r;
            front_g_nx = back_g;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= 3'd0;
            front_sel   <= 1'b0;
            swap_fire_q <= 1'b0;
            swap_done   <= 1'b0;
            r_a         <= '0;
            g_a         <= '0;
            r_b         <= '0;
            g_b         <= '0;
            matrix_r    <= '0;
            matrix_g    <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= clr_busy ? row_q + 3'd1 : 3'd0;
            front_sel   <= front_sel ^ swap_fire;
            swap_fire_q <= swap_fire;
            swap_done   <= swap_fire_q;
            r_a         <= front_sel ? back_r_nx : front_r_nx;
            g_a         <= front_sel ? back_g_nx : front_g_nx;
            r_b         <= front_sel ? front_r_nx : back_r_nx;
            g_b         <= front_sel ? front_g_nx : back_g_nx;
            matrix_r    <= front_r;
            matrix_g    <= front_g;
        end
    end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomised bench for led_frame_buffer against a bank-level image model.
module tb_led_frame_buffer;

    localparam logic [1:0] CLR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready;
    logic [2:0]  wr_x, wr_y;
    logic [1:0]  wr_color;
    logic        clr_req, clr_busy;
    logic        swap_req, frame_start, swap_pend, swap_done;
    logic [63:0] matrix_r, matrix_g;

    int checks = 0;
    int failures = 0;

    logic [63:0] mr [2];
    logic [63:0] mg [2];
    int          mfront;

    led_frame_buffer #(.CLR_COLOR(CLR)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .swap_req(swap_req), .frame_start(frame_start),
        .swap_pend(swap_pend), .swap_done(swap_done),
        .matrix_r(matrix_r), .matrix_g(matrix_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic zero_inputs();
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_color = 0;
        clr_req = 0; swap_req = 0; frame_start = 0;
    endtask

    task automatic model_reset();
        mr[0] = '0; mr[1] = '0; mg[0] = '0; mg[1] = '0;
        mfront = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mr"}, matrix_r, 64'h0);
        check({tag, "_mg"}, matrix_g, 64'h0);
        check({tag, "_busy"}, clr_busy, 0);
        check({tag, "_pend"}, swap_pend, 0);
        check({tag, "_done"}, swap_done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst = 1;
        #1 check_zero_outputs("rst");
        model_reset();
        @(negedge clk);
        rst = 0;
        #1 check("rst_wr_ready", wr_ready, 1);
    endtask

    task automatic do_write(input int x, input int y, input int c);
        @(negedge clk);
        wr_valid = 1; wr_x = 3'(x); wr_y = 3'(y); wr_color = 2'(c);
        #1 check("wr_ready", wr_ready, 1);
        check("wr_busy", clr_busy, 0);
        check("wr_hidden_r", matrix_r, mr[mfront]);
        check("wr_hidden_g", matrix_g, mg[mfront]);
        @(negedge clk);
        wr_valid = 0;
        mr[1-mfront][8*y+x] = c[0];
        mg[1-mfront][8*y+x] = c[1];
    endtask

    task automatic do_clear(input int abort_at);
        int cnt;
        @(negedge clk);
        clr_req = 1;
        swap_req = 1'($urandom_range(0, 1));
        wr_valid = 1'($urandom_range(0, 1));
        wr_x = 3'($urandom); wr_y = 3'($urandom); wr_color = 2'($urandom);
        #1 check("clr_entry_ready", wr_ready, 0);
        @(negedge clk);
        zero_inputs();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!clr_busy) break;
            cnt++;
            check("clr_wr_ready", wr_ready, 0);
            check("clr_pend", swap_pend, 0);
            if (cnt == abort_at) begin
                zero_inputs();
                rst = 1;
                #1 check_zero_outputs("abort");
                model_reset();
                @(negedge clk);
                rst = 0;
                #1 check("abort_wr_ready", wr_ready, 1);
                check("abort_busy", clr_busy, 0);
                return;
            end
            clr_req = 1'($urandom_range(0, 1));
            swap_req = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            frame_start = 1'($urandom_range(0, 1));
            wr_x = 3'($urandom); wr_y = 3'($urandom); wr_color = 2'($urandom);
            @(negedge clk);
        end
        zero_inputs();
        #1 check("clr_len", cnt, 8);
        check("clr_after_pend", swap_pend, 0);
        check("clr_after_ready", wr_ready, 1);
        mr[1-mfront] = {64{CLR[0]}};
        mg[1-mfront] = {64{CLR[1]}};
    endtask

    task automatic do_swap(input int delay, input bit coinc);
        @(negedge clk);
        swap_req = 1; frame_start = coinc;
        wr_valid = 1'($urandom_range(0, 1));
        wr_x = 3'($urandom); wr_y = 3'($urandom); wr_color = 2'($urandom);
        #1 check("swap_req_ready", wr_ready, 0);
        check("swap_req_pend", swap_pend, 0);
        @(negedge clk);
        zero_inputs();
        for (int i = 0; i < delay; i++) begin
            #1 check("wait_pend", swap_pend, 1);
            check("wait_done", swap_done, 0);
            check("wait_mr", matrix_r, mr[mfront]);
            swap_req = 1'($urandom_range(0, 1));
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 3'($urandom); wr_y = 3'($urandom); wr_color = 2'($urandom);
            @(negedge clk);
        end
        #1 check("fs_pend", swap_pend, 1);
        frame_start = 1;
        @(negedge clk);
        zero_inputs();
        #1 check("post_pend", swap_pend, 0);
        check("post_done_early", swap_done, 0);
        check("post_old_mr", matrix_r, mr[mfront]);
        mfront = 1 - mfront;
`ifdef FB_COPY_ON_SWAP_EN
        mr[1-mfront] = mr[mfront];
        mg[1-mfront] = mg[mfront];
`endif
        @(negedge clk);
        #1 check("swap_done", swap_done, 1);
        check("swap_mr", matrix_r, mr[mfront]);
        check("swap_mg", matrix_g, mg[mfront]);
        @(negedge clk);
        #1 check("swap_done_pulse", swap_done, 0);
    endtask

    initial begin
        rst = 0;
        zero_inputs();
        model_reset();
        do_reset();

        // reset in the middle of a clear
        do_write($urandom_range(0, 7), $urandom_range(0, 7), 3);
        do_swap(3, 0);
        do_clear(4);
        do_swap(2, 0);

        do_reset();
        do_write(3, 2, 1);
        do_swap(10, 0);
        check("t2_r", matrix_r, 64'h0000_0000_0008_0000);
        check("t2_g", matrix_g, 64'h0);

        do_clear(0);
        do_swap(1, 0);
        check("t3_r", matrix_r, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_g", matrix_g, 64'hFFFF_FFFF_FFFF_FFFF);

        do_swap(4, 1);

        do_reset();
        do_write(0, 0, 1);
        do_swap(2, 0);
        do_write(7, 7, 1);
        do_swap(2, 0);
`ifdef FB_COPY_ON_SWAP_EN
        check("t6_r", matrix_r, 64'h8000_0000_0000_0001);
`else
        check("t6_r", matrix_r, 64'h8000_0000_0000_0000);
`endif

        repeat (60) begin
            case ($urandom_range(0, 4))
                0, 1, 2: do_write($urandom_range(0, 7), $urandom_range(0, 7),
                                  $urandom_range(0, 3));
                3: do_clear(0);
                default: do_swap($urandom_range(0, 12), 1'($urandom_range(0, 1)));
            endcase
        end
        do_swap(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
